// File: rtl/modq3259_pkg.sv
// Shared constants for arithmetic modulo q = 3259.
// Widths follow the worst-case bound of each datapath stage.
package modq3259_pkg;

    localparam int unsigned Q        = 3259;
    localparam int unsigned MU       = 5147;
    localparam int unsigned MU_SHIFT = 24;
    localparam int unsigned FOLD_C   = 837;

    localparam int unsigned W_COEF = 12;
    localparam int unsigned W_PROD = 24;
    localparam int unsigned W_FOLD = 22;
    localparam int unsigned W_RED  = 13;
    // f * MU peaks just above 2^34.
    localparam int unsigned W_MUP  = 35;
    localparam int unsigned W_QUOT = 11;

    typedef logic [W_COEF-1:0] coef_t;
    typedef logic [W_PROD-1:0] prod_t;
    typedef logic [W_FOLD-1:0] fold_t;
    typedef logic [W_RED-1:0]  red_t;

endpackage

// File: rtl/modmul_pipe_3259_if.sv
// Operand/result streaming channels of the mod-3259 multiplier.
interface modmul_pipe_3259_if
    import modq3259_pkg::*;
#(
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    coef_t            in_a;
    coef_t            in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    coef_t            out_r;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_r, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_r, out_tag
    );

endinterface

// File: rtl/barrett_reduce_3259_core.sv
// Combinational Barrett step: f < 2^22 -> r = f - floor(f*MU / 2^24)*q, with r < 2q.
module barrett_reduce_3259_core
    import modq3259_pkg::*;
(
    input  fold_t f_i,
    output red_t  r_o
);

    logic [W_MUP-1:0]  prod;
    logic [W_QUOT-1:0] t;
    fold_t             tq;

    assign prod = W_MUP'(f_i) * W_MUP'(MU);
    assign t    = W_QUOT'(prod >> MU_SHIFT);
    // t never exceeds floor(f/q), so the subtraction cannot wrap.
    assign tq   = W_FOLD'(t) * W_FOLD'(Q);
    assign r_o  = W_RED'(f_i - tq);

endmodule

// File: rtl/modmul_pipe_3259.sv
// Four-stage pipelined (a*b) mod 3259 with bubble-collapsing valid/ready flow control.
module modmul_pipe_3259
    import modq3259_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    modmul_pipe_3259_if.slave  bus,
    output logic               busy
);

    logic en1, en2, en3, en4;
    logic v1_q, v2_q, v3_q, v4_q;
    logic v1_d, v2_d, v3_d, v4_d;

    prod_t            p1_q, p1_d;
    fold_t            f2_q, f2_d;
    red_t             r3_q, r3_d;
    coef_t            o4_q, o4_d;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q, tag4_q;
    logic [TAG_W-1:0] tag1_d, tag2_d, tag3_d, tag4_d;

    red_t r3_calc;

    barrett_reduce_3259_core u_barrett (
        .f_i (f2_q),
        .r_o (r3_calc)
    );

    // Each stage may load if it is empty or the stage after it is moving.
    always_comb begin
        en4 = !v4_q || bus.out_ready;
        en3 = !v3_q || en4;
        en2 = !v2_q || en3;
        en1 = !v1_q || en2;
    end

    always_comb begin
        v1_d   = v1_q;
        v2_d   = v2_q;
        v3_d   = v3_q;
        v4_d   = v4_q;
        p1_d   = p1_q;
        f2_d   = f2_q;
        r3_d   = r3_q;
        o4_d   = o4_q;
        tag1_d = tag1_q;
        tag2_d = tag2_q;
        tag3_d = tag3_q;
        tag4_d = tag4_q;
        if (en1) begin
            v1_d   = bus.in_valid;
            p1_d   = W_PROD'(bus.in_a) * W_PROD'(bus.in_b);
            tag1_d = bus.in_tag;
        end
        if (en2) begin
            v2_d   = v1_q;
            f2_d   = W_FOLD'(p1_q[W_PROD-1:W_COEF]) * W_FOLD'(FOLD_C)
                   + W_FOLD'(p1_q[W_COEF-1:0]);
            tag2_d = tag1_q;
        end
        if (en3) begin
            v3_d   = v2_q;
            r3_d   = r3_calc;
            tag3_d = tag2_q;
        end
        if (en4) begin
            v4_d   = v3_q;
            o4_d   = (r3_q >= W_RED'(Q)) ? W_COEF'(r3_q - W_RED'(Q)) : W_COEF'(r3_q);
            tag4_d = tag3_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            v4_q   <= 1'b0;
            p1_q   <= '0;
            f2_q   <= '0;
            r3_q   <= '0;
            o4_q   <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
            tag4_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            v4_q   <= v4_d;
            p1_q   <= p1_d;
            f2_q   <= f2_d;
            r3_q   <= r3_d;
            o4_q   <= o4_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
            tag3_q <= tag3_d;
            tag4_q <= tag4_d;
        end
    end

    assign bus.in_ready  = en1;
    assign bus.out_valid = v4_q;
    assign bus.out_r     = o4_q;
    assign bus.out_tag   = tag4_q;
    assign busy          = v1_q | v2_q | v3_q | v4_q;

endmodule
